pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised next-generation program-counter unit for the single-cycle/early-pipeline core.
//  - Holds the architectural PC and selects the next PC from: sequential, beq/bne, j/jal, jr and trap.
//  - Supports fetch stall (core stall or instruction memory not ready).
//  - Keeps a return-address stack (RAS) and counts jr return-address mismatches.
//  - Sits between the controller/ALU and the instruction memory address port.
// PARAMETERS
//  XLEN       32            PC/data width (>= 28)
//  RESET_VEC  32'h0000_0000 PC value loaded on reset
//  TRAP_VEC   32'h0000_0100 redirect target on misaligned target (PC_MISALIGN_TRAP_EN only)
//  RAS_DEPTH  4             return-address stack entries (power of 2, >= 2)
//  CNT_W      16            width of the jr mismatch counter
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          reset, asynchronous, active-low
//  stall        in   1          core stall; hold PC
//  imem_ready   in   1          instruction memory accepts the address this cycle
//  branch       in   1          beq from controller
//  n_branch     in   1          bne from controller
//  zero         in   1          ALU equality flag (1 = operands equal)
//  jmp          in   1          j from controller
//  jal          in   1          jal from controller
//  jr           in   1          jr from controller
//  instr_index  in   26         instruction[25:0] jump index
//  addr_result  in   XLEN       branch target from the address adder
//  read_data_1  in   XLEN       rs value (jr target)
//  pc           out  XLEN       current PC / fetch address
//  pc_plus_4    out  XLEN       pc + 4 (combinational)
//  link_addr    out  XLEN       jal return address to the register file (= pc + 4)
//  fetch_valid  out  1          pc is a valid fetch request
//  ras_miss_cnt out  CNT_W      jr targets that did not match the RAS top
//  trap         out  1          one-cycle pulse: misaligned redirect taken
//  epc          out  XLEN       PC of the faulting control instruction
// BEHAVIOUR
//  - Reset: pc = RESET_VEC; fetch_valid = 0; ras_miss_cnt = 0; trap = 0; epc = 0; RAS empty; state BOOT.
//  - FSM:
//    - BOOT: unconditionally goes to RUN on the next clock. pc is unchanged; fetch_valid = 0.
//    - RUN: fetch_valid = 1. If stall or !imem_ready, go to HOLD and keep pc. Otherwise load next_pc.
//    - HOLD: fetch_valid = 1 and pc is held. Control inputs are ignored.
//      When stall = 0 and imem_ready = 1, return to RUN. No redirect is issued that cycle.
//      The controller re-presents the instruction's controls in RUN.
//  - next_pc priority, highest first:
//    1. trap
//    2. jr: read_data_1
//    3. jal/jmp: {pc[XLEN-1:28], instr_index, 2'b00}
//    4. (branch & zero) | (n_branch & ~zero): addr_result
//    5. pc + 4
//  - jal loads the jump target directly; link_addr = pc + 4 in that same cycle. No extra delay slot.
//  - All additions wrap modulo 2^XLEN. pc = all-ones-minus-3 advances to 0.
//  - RAS: a circular buffer with a top pointer and an occupancy count 0..RAS_DEPTH. Updates only on advancing cycles.
//    - jal pushes pc + 4. When full, the oldest entry is overwritten and count saturates.
//    - jr pops. If count = 0 or the top entry != read_data_1, ras_miss_cnt increments (saturating at all-ones).
//    - A pop when empty leaves count at 0.
//    - The RAS never changes the architectural next_pc.
//  - Reset asserted mid-operation immediately restores all reset values, whatever the state.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//    - On an advancing cycle, if the selected next_pc has next_pc[1:0] != 0, then pc = TRAP_VEC, epc = pc and trap = 1 for one cycle.
//    - No RAS push or pop happens in that cycle.
//  PC_MISALIGN_TRAP_EN undefined:
//    - next_pc[1:0] is forced to 2'b00.
//    - trap and epc are tied to 0.
// STRUCTURE
//  - Package pc_pkg: state enum {BOOT, RUN, HOLD}; next-pc select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_TRAP}; localparam INSN_BYTES = 4.
//  - Sub-module pc_ras (params XLEN, RAS_DEPTH):
//    - inputs: push, pop, push_data
//    - outputs: top, empty
//  - Everything else lives in pc_gen.
// TESTING
//  1. Reset, then 3 clocks with no control: pc = 0 (BOOT), 0, 4, 8; fetch_valid goes 0->1 after the first edge.
//  2. pc = 0x40, branch = 1, zero = 1, addr_result = 0x80: pc = 0x80.
//     Same cycle with n_branch = 1, zero = 1: pc = 0x44.
//  3. pc = 0x1000_0010, jal = 1, instr_index = 0x40: pc = 0x1000_0100 and link_addr = 0x1000_0014 in the jal cycle.
//     A later jr with read_data_1 = 0x1000_0014 leaves ras_miss_cnt = 0.
//  4. Push RAS_DEPTH + 1 jals, then RAS_DEPTH + 1 jrs with matching targets: exactly one miss (the overwritten oldest entry).
//  5. imem_ready = 0 for 3 cycles with jmp asserted: pc is held and state is HOLD.
//     On release: RUN, then pc + 4 unless controls are re-presented.
//  6. PC_MISALIGN_TRAP_EN, jr with read_data_1 = 0x102: pc = 0x100, epc = old pc, one-cycle trap pulse.
//     With the macro undefined: pc = 0x100 and trap stays 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM states and next-PC source select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

   // Fetch FSM: BOOT spends one cycle after reset, RUN advances, HOLD waits out a stall.
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } pc_state_e;

   // Source of the next PC, in increasing priority order.
   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_J    = 3'd2,
      SEL_JR   = 3'd3,
      SEL_TRAP = 3'd4
   } pc_sel_e;

   localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating occupancy count.
// Latency: push/pop take effect on the next clock; top/empty are combinational from state.
// Backpressure: none; a push when full overwrites the oldest entry, a pop when empty is a no-op.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (stack empties on reset)
//   push         write push_data as the new top
//   pop          discard the top entry
//   push_data    value to push
//   top          current top entry (undefined content when empty)
//   empty        occupancy is zero
module pc_ras #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = RAS_DEPTH[PTR_W:0];

   logic [XLEN-1:0]  mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_q;
   logic [PTR_W-1:0] push_ptr;
   logic [PTR_W:0]   cnt_q;

   // Power-of-two depth: the pointer wraps naturally, so a push when full
   // lands on the oldest slot.
   assign push_ptr = top_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= '0;
         cnt_q <= '0;
      end else if (push) begin
         top_q <= push_ptr;
         if (cnt_q != FULL_CNT) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (pop && (cnt_q != '0)) begin
         top_q <= top_q - 1'b1;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Storage needs no reset: entries are only read while the count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[push_ptr] <= push_data;
      end
   end

   assign top   = mem[top_q];
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: holds the PC, picks next PC (seq/branch/jump/jr/trap), tracks a RAS.
// Latency: PC updates one clock after an advancing RUN cycle; pc_plus_4/link_addr are combinational.
// Backpressure: stall or !imem_ready parks the FSM in HOLD with the PC frozen and controls ignored.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall, imem_ready          fetch hold conditions
//   branch, n_branch, zero     beq/bne and ALU equality flag
//   jmp, jal, jr               jump controls
//   instr_index                26-bit jump index
//   addr_result, read_data_1   branch target and jr target
//   pc, pc_plus_4, link_addr   current PC, PC+4, jal return address
//   fetch_valid                pc is a valid fetch request (not in BOOT)
//   ras_miss_cnt               saturating count of jr targets not matching the RAS top
//   trap, epc                  misaligned-redirect pulse and faulting PC
//
// Build option: define PC_MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VEC
// (raising trap/epc); otherwise target bits [1:0] are cleared and trap/epc read 0.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
   parameter int              RAS_DEPTH = 4,
   parameter int              CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             imem_ready,
   input  logic             branch,
   input  logic             n_branch,
   input  logic             zero,
   input  logic             jmp,
   input  logic             jal,
   input  logic             jr,
   input  logic [25:0]      instr_index,
   input  logic [XLEN-1:0]  addr_result,
   input  logic [XLEN-1:0]  read_data_1,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus_4,
   output logic [XLEN-1:0]  link_addr,
   output logic             fetch_valid,
   output logic [CNT_W-1:0] ras_miss_cnt,
   output logic             trap,
   output logic [XLEN-1:0]  epc
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

   pc_state_e        state_q, state_d;
   logic [XLEN-1:0]  pc_q;
   logic [CNT_W-1:0] miss_cnt_q;

   pc_sel_e          sel_raw, sel_final;
   logic [XLEN-1:0]  raw_tgt;
   logic [XLEN-1:0]  j_tgt;
   logic [XLEN-1:0]  next_pc;
   logic             br_taken;
   logic             misalign;
   logic             advance;

   logic             ras_push, ras_pop;
   logic [XLEN-1:0]  ras_top;
   logic             ras_empty;

   assign pc          = pc_q;
   assign pc_plus_4   = pc_q + XLEN'(INSN_BYTES);
   assign link_addr   = pc_plus_4;
   assign fetch_valid = (state_q != BOOT);

   // Only RUN with fetch not held moves the PC and touches the RAS.
   assign advance = (state_q == RUN) && !stall && imem_ready;

   // ---------------------------------------------------------------------
   // Next-PC selection
   // ---------------------------------------------------------------------
   always_comb begin
      br_taken = (branch & zero) | (n_branch & ~zero);

      // Jump keeps the PC's upper bits above the 28-bit region.
      j_tgt       = pc_q;
      j_tgt[27:0] = {instr_index, 2'b00};

      sel_raw = SEL_SEQ;
      if (jr) begin
         sel_raw = SEL_JR;
      end else if (jal || jmp) begin
         sel_raw = SEL_J;
      end else if (br_taken) begin
         sel_raw = SEL_BR;
      end

      case (sel_raw)
         SEL_JR:  raw_tgt = read_data_1;
         SEL_J:   raw_tgt = j_tgt;
         SEL_BR:  raw_tgt = addr_result;
         default: raw_tgt = pc_plus_4;
      endcase
   end

`ifdef PC_MISALIGN_TRAP_EN
   assign misalign = (raw_tgt[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      sel_final = misalign ? SEL_TRAP : sel_raw;
      if (sel_final == SEL_TRAP) begin
         next_pc = TRAP_VEC;
      end else begin
         next_pc = raw_tgt & ALIGN_MASK;
      end
   end

   // ---------------------------------------------------------------------
   // Fetch FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN:  if (stall || !imem_ready) state_d = HOLD;
         HOLD: if (!stall && imem_ready) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VEC;
      end else begin
         state_q <= state_d;
         if (advance) begin
            pc_q <= next_pc;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Return-address stack and jr mismatch counter
   // ---------------------------------------------------------------------
   // A trapping cycle leaves the RAS alone; jr outranks jal, so at most one
   // of push/pop is asserted.
   assign ras_push = advance && (sel_final == SEL_J) && jal;
   assign ras_pop  = advance && (sel_final == SEL_JR);

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus_4),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt_q <= '0;
      end else if (ras_pop && (ras_empty || (ras_top != read_data_1))
                   && (miss_cnt_q != '1)) begin
         miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
   end

   assign ras_miss_cnt = miss_cnt_q;

   // ---------------------------------------------------------------------
   // Misaligned-redirect trap
   // ---------------------------------------------------------------------
`ifdef PC_MISALIGN_TRAP_EN
   logic            trap_q;
   logic [XLEN-1:0] epc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q <= 1'b0;
         epc_q  <= '0;
      end else begin
         trap_q <= advance && (sel_final == SEL_TRAP);
         if (advance && (sel_final == SEL_TRAP)) begin
            epc_q <= pc_q;
         end
      end
   end

   assign trap = trap_q;
   assign epc  = epc_q;
`else
   assign trap = 1'b0;
   assign epc  = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized control traffic
// checked against a queue-based behavioural model of the PC unit.
module tb_pc_gen;
   import pc_pkg::*;

   localparam int          RAS_DEPTH = 4;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        stall, imem_ready;
   logic        branch, n_branch, zero;
   logic        jmp, jal, jr;
   logic [25:0] instr_index;
   logic [31:0] addr_result, read_data_1;
   logic [31:0] pc, pc_plus_4, link_addr, epc;
   logic        fetch_valid, trap;
   logic [15:0] ras_miss_cnt;

   pc_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .imem_ready   (imem_ready),
      .branch       (branch),
      .n_branch     (n_branch),
      .zero         (zero),
      .jmp          (jmp),
      .jal          (jal),
      .jr           (jr),
      .instr_index  (instr_index),
      .addr_result  (addr_result),
      .read_data_1  (read_data_1),
      .pc           (pc),
      .pc_plus_4    (pc_plus_4),
      .link_addr    (link_addr),
      .fetch_valid  (fetch_valid),
      .ras_miss_cnt (ras_miss_cnt),
      .trap         (trap),
      .epc          (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 = just out of reset, 1 = fetching, 2 = waiting on a stall
   int          m_mode;
   bit [31:0]   m_pc, m_epc;
   bit          m_trap;
   int unsigned m_miss;
   bit [31:0]   m_ras[$];   // index 0 = most recent return address

   task automatic m_reset();
      m_mode = 0;
      m_pc   = RESET_VEC;
      m_epc  = 0;
      m_trap = 0;
      m_miss = 0;
      m_ras.delete();
   endtask

   task automatic m_clock();
      bit [31:0] t;
      bit        adv;
      adv    = 0;
      m_trap = 0;
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
         if (stall || !imem_ready) m_mode = 2;
         else adv = 1;
      end else if (!stall && imem_ready) m_mode = 1;

      if (adv) begin
         if (jr) t = read_data_1;
         else if (jal || jmp) t = {m_pc[31:28], instr_index, 2'b00};
         else if ((branch && zero) || (n_branch && !zero)) t = addr_result;
         else t = m_pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
         if (t[1:0] != 2'b00) begin
            m_epc  = m_pc;
            m_trap = 1;
            m_pc   = TRAP_VEC;
         end else begin
`else
         t[1:0] = 2'b00;
         begin
`endif
            if (jr) begin
               if (m_ras.size() == 0 || m_ras[0] != read_data_1) begin
                  if (m_miss < 32'hFFFF) m_miss++;
               end
               if (m_ras.size() != 0) void'(m_ras.pop_front());
            end else if (jal) begin
               m_ras.push_front(m_pc + 32'd4);
               if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_back());
            end
            m_pc = t;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".pc"},    64'(pc),           64'(m_pc));
      chk({tag, ".pc4"},   64'(pc_plus_4),    64'(m_pc + 32'd4));
      chk({tag, ".link"},  64'(link_addr),    64'(m_pc + 32'd4));
      chk({tag, ".fv"},    64'(fetch_valid),  64'(m_mode != 0));
      chk({tag, ".miss"},  64'(ras_miss_cnt), 64'(m_miss));
`ifdef PC_MISALIGN_TRAP_EN
      chk({tag, ".trap"},  64'(trap),         64'(m_trap));
      chk({tag, ".epc"},   64'(epc),          64'(m_epc));
`else
      chk({tag, ".trap"},  64'(trap),         64'(0));
      chk({tag, ".epc"},   64'(epc),          64'(0));
`endif
   endtask

   // Check current outputs, clock once, advance the model, settle.
   task automatic cyc(input string tag);
      check_outputs(tag);
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic idle();
      stall = 0; imem_ready = 1;
      branch = 0; n_branch = 0; zero = 0;
      jmp = 0; jal = 0; jr = 0;
      instr_index = '0; addr_result = '0; read_data_1 = '0;
   endtask

   initial begin
      bit [31:0] pushed[RAS_DEPTH+1];
      bit [31:0] p0;
      int        kind;

      idle();
      rst_n = 0;
      m_reset();
      #12;
      check_outputs("rst");
      chk("rst.state", 64'(dut.state_q), 64'(BOOT));
      rst_n = 1;

      // 1: BOOT then sequential fetch
      cyc("t1a");
      chk("t1.pc_boot", 64'(pc), 64'h0);
      chk("t1.fv_up",   64'(fetch_valid), 64'h1);
      cyc("t1b");
      chk("t1.pc4", 64'(pc), 64'h4);
      cyc("t1c");
      chk("t1.pc8", 64'(pc), 64'h8);

      // 2: beq taken, bne not taken
      jmp = 1; instr_index = 26'h10; cyc("t2j"); idle();
      chk("t2.pc40", 64'(pc), 64'h40);
      branch = 1; zero = 1; addr_result = 32'h80; cyc("t2beq"); idle();
      chk("t2.beq", 64'(pc), 64'h80);
      jmp = 1; instr_index = 26'h10; cyc("t2j2"); idle();
      n_branch = 1; zero = 1; addr_result = 32'h80; cyc("t2bne"); idle();
      chk("t2.bne", 64'(pc), 64'h44);

      // 3: jal target/link, then matching jr
      branch = 1; zero = 1; addr_result = 32'h1000_0010; cyc("t3br"); idle();
      chk("t3.pc", 64'(pc), 64'h1000_0010);
      jal = 1; instr_index = 26'h40;
      chk("t3.link", 64'(link_addr), 64'h1000_0014);
      cyc("t3jal"); idle();
      chk("t3.jal", 64'(pc), 64'h1000_0100);
      cyc("t3gap");
      jr = 1; read_data_1 = 32'h1000_0014; cyc("t3jr"); idle();
      chk("t3.jr_pc", 64'(pc), 64'h1000_0014);
      chk("t3.miss0", 64'(ras_miss_cnt), 64'h0);

      // 4: RAS overflow, exactly one miss
      for (int i = 0; i <= RAS_DEPTH; i++) begin
         pushed[i] = m_pc + 32'd4;
         jal = 1; instr_index = 26'(32'h100 * (i + 1));
         cyc("t4jal"); idle();
      end
      for (int i = RAS_DEPTH; i >= 0; i--) begin
         jr = 1; read_data_1 = pushed[i];
         cyc("t4jr"); idle();
      end
      chk("t4.miss1", 64'(ras_miss_cnt), 64'h1);

      // 5: imem not ready with jmp held
      p0 = m_pc;
      jmp = 1; instr_index = 26'h200; imem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cyc("t5hold");
         chk("t5.pc_held", 64'(pc), 64'(p0));
         chk("t5.state", 64'(dut.state_q), 64'(HOLD));
      end
      imem_ready = 1;
      cyc("t5rel");
      chk("t5.rel_pc", 64'(pc), 64'(p0));
      chk("t5.rel_state", 64'(dut.state_q), 64'(RUN));
      idle();
      cyc("t5seq");
      chk("t5.seq", 64'(pc), 64'(p0 + 32'd4));

      // 6: misaligned jr target
      p0 = m_pc;
      jr = 1; read_data_1 = 32'h102; cyc("t6jr"); idle();
      chk("t6.pc", 64'(pc), 64'h100);
`ifdef PC_MISALIGN_TRAP_EN
      chk("t6.trap", 64'(trap), 64'h1);
      chk("t6.epc",  64'(epc),  64'(p0));
      cyc("t6after");
      chk("t6.trap_pulse", 64'(trap), 64'h0);
`else
      chk("t6.trap0", 64'(trap), 64'h0);
      cyc("t6after");
`endif

      // Randomized traffic with one asynchronous reset mid-run
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            rst_n = 0;
            #1;
            m_reset();
            check_outputs("arst");
            chk("arst.state", 64'(dut.state_q), 64'(BOOT));
            @(negedge clk);
            rst_n = 1;
         end
         idle();
         stall       = ($urandom_range(0, 7) == 0);
         imem_ready  = ($urandom_range(0, 5) != 0);
         branch      = 1'($urandom);
         n_branch    = 1'($urandom);
         zero        = 1'($urandom);
         instr_index = 26'($urandom);
         addr_result = $urandom;
         if ($urandom_range(0, 3) != 0) addr_result[1:0] = 2'b00;
         kind = $urandom_range(0, 5);
         jmp = (kind == 1);
         jal = (kind == 2);
         jr  = (kind == 3);
         if (m_ras.size() != 0 && $urandom_range(0, 1) == 1) read_data_1 = m_ras[0];
         else begin
            read_data_1 = $urandom;
            if ($urandom_range(0, 3) != 0) read_data_1[1:0] = 2'b00;
         end
         cyc("rnd");
      end
      check_outputs("end");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
